// File: rtl/cnn_rx_pkg.sv
// Shared types and default dimensions for the CNN log-mel window receiver.
// Optional build macro for this block: CNN_FEATURE_RX_ERR_EN (sticky protocol error).
package cnn_rx_pkg;

  localparam int DEF_OUT_W    = 16;
  localparam int DEF_N_MELS   = 40;
  localparam int DEF_N_FRAMES = 32;

  typedef enum logic {
    FILL   = 1'b0,
    WINDOW = 1'b1
  } rx_state_e;

  // Modular add done explicitly so non-power-of-two frame counts wrap correctly.
  // Assumes both operands are already below n.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/cnn_rx_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// The array is never reset; only the read register is.
module cnn_rx_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1280,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/cnn_feature_rx.sv
// Collects a log-mel stream into an N_FRAMES x N_MELS sliding window for a CNN.
// Build macro CNN_FEATURE_RX_ERR_EN enables the sticky err_ol on releases seen in FILL.
module cnn_feature_rx
  import cnn_rx_pkg::*;
#(
  parameter int OUT_W      = DEF_OUT_W,
  parameter int N_MELS     = DEF_N_MELS,
  parameter int N_FRAMES   = DEF_N_FRAMES,
  parameter int HOP_FRAMES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [OUT_W-1:0]              cnn_data_il,
  input  logic                          cnn_valid_il,
  output logic                          cnn_ready_ol,
  output logic                          win_valid_ol,
  input  logic                          win_release_il,
  input  logic [$clog2(N_FRAMES)-1:0]   rd_frame_il,
  input  logic [$clog2(N_MELS)-1:0]     rd_mel_il,
  output logic [OUT_W-1:0]              rd_data_ol,
  output logic [$clog2(N_FRAMES+1)-1:0] frames_held_ol,
  output logic                          err_ol,
  output logic                          dbg_state_o
);

  localparam int FR_W   = $clog2(N_FRAMES);
  localparam int MEL_W  = $clog2(N_MELS);
  localparam int HELD_W = $clog2(N_FRAMES + 1);
  localparam int DEPTH  = N_FRAMES * N_MELS;
  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [MEL_W-1:0]  MEL_LAST  = MEL_W'(N_MELS - 1);
  localparam logic [HELD_W-1:0] HELD_LAST = HELD_W'(N_FRAMES - 1);
  localparam logic [HELD_W-1:0] HOP       = HELD_W'(HOP_FRAMES);

  rx_state_e         state_q, state_d;
  logic [MEL_W-1:0]  mel_idx_q, mel_idx_d;
  logic [FR_W-1:0]   wr_frame_q, wr_frame_d;
  logic [FR_W-1:0]   rd_base_q, rd_base_d;
  logic [HELD_W-1:0] frames_held_q, frames_held_d;

  logic              accept;
  logic              frame_done;
  logic              release_ok;
  logic [FR_W-1:0]   rd_phys;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  // Handshake: a sample transfers on a rising edge where cnn_valid_il and
  // cnn_ready_ol are both high; valid may be held high while ready is low and
  // nothing is taken. win_valid_ol/win_release_il form a pulse-release pair.
  assign cnn_ready_ol = (state_q == FILL);
  assign win_valid_ol = (state_q == WINDOW);
  assign dbg_state_o  = state_q;

  assign accept     = cnn_valid_il && cnn_ready_ol;
  assign frame_done = accept && (mel_idx_q == MEL_LAST);
  assign release_ok = win_release_il && (state_q == WINDOW);

  always_comb begin
    state_d       = state_q;
    mel_idx_d     = mel_idx_q;
    wr_frame_d    = wr_frame_q;
    rd_base_d     = rd_base_q;
    frames_held_d = frames_held_q;
    if (accept) begin
      mel_idx_d = frame_done ? '0 : mel_idx_q + 1'b1;
    end
    if (frame_done) begin
      wr_frame_d    = FR_W'(wrap_add(int'(wr_frame_q), 1, N_FRAMES));
      frames_held_d = frames_held_q + 1'b1;
      if (frames_held_q == HELD_LAST) begin
        state_d = WINDOW;
      end
    end
    if (release_ok) begin
      frames_held_d = frames_held_q - HOP;
      rd_base_d     = FR_W'(wrap_add(int'(rd_base_q), HOP_FRAMES, N_FRAMES));
      state_d       = FILL;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= FILL;
      mel_idx_q     <= '0;
      wr_frame_q    <= '0;
      rd_base_q     <= '0;
      frames_held_q <= '0;
    end else begin
      state_q       <= state_d;
      mel_idx_q     <= mel_idx_d;
      wr_frame_q    <= wr_frame_d;
      rd_base_q     <= rd_base_d;
      frames_held_q <= frames_held_d;
    end
  end

  assign frames_held_ol = frames_held_q;

  // Logical frame 0 is the oldest held frame, which sits at rd_base.
  assign rd_phys = FR_W'(wrap_add(int'(rd_base_q), int'(rd_frame_il), N_FRAMES));
  assign wr_addr = ADDR_W'(int'(wr_frame_q) * N_MELS + int'(mel_idx_q));
  assign rd_addr = ADDR_W'(int'(rd_phys) * N_MELS + int'(rd_mel_il));

  cnn_rx_ram #(
    .DATA_W (OUT_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (accept),
    .wr_addr_i (wr_addr),
    .wr_data_i (cnn_data_il),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data_ol)
  );

`ifdef CNN_FEATURE_RX_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (win_release_il && (state_q == FILL)) begin
      err_q <= 1'b1;
    end
  end

  assign err_ol = err_q;
`else
  assign err_ol = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_feature_rx.sv
// Directed bench for cnn_feature_rx with default parameters (16 x 40 x 32, hop 16).
module tb_cnn_feature_rx;
  import cnn_rx_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] cnn_data;
  logic        cnn_valid;
  logic        cnn_ready;
  logic        win_valid;
  logic        win_release;
  logic [4:0]  rd_frame;
  logic [5:0]  rd_mel;
  logic [15:0] rd_data;
  logic [5:0]  frames_held;
  logic        err;
  logic        dbg_state;

  int checks = 0;
  int errors = 0;

  cnn_feature_rx dut (
    .clk            (clk),
    .reset          (reset),
    .cnn_data_il    (cnn_data),
    .cnn_valid_il   (cnn_valid),
    .cnn_ready_ol   (cnn_ready),
    .win_valid_ol   (win_valid),
    .win_release_il (win_release),
    .rd_frame_il    (rd_frame),
    .rd_mel_il      (rd_mel),
    .rd_data_ol     (rd_data),
    .frames_held_ol (frames_held),
    .err_ol         (err),
    .dbg_state_o    (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks happen at that point too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v);
    cnn_data  = v;
    cnn_valid = 1'b1;
    tick();
    cnn_valid = 1'b0;
  endtask

  task automatic send_frames(input int first_frame, input int n);
    for (int f = 0; f < n; f++) begin
      for (int m = 0; m < 40; m++) begin
        send(16'((first_frame + f) * 40 + m));
      end
    end
  endtask

  task automatic rd_check(input string tag, input int f, input int m, input int exp);
    rd_frame = 5'(f);
    rd_mel   = 6'(m);
    tick();
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic release_pulse();
    win_release = 1'b1;
    tick();
    win_release = 1'b0;
  endtask

  logic exp_err;

  initial begin
`ifdef CNN_FEATURE_RX_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    reset       = 1'b0;
    cnn_data    = '0;
    cnn_valid   = 1'b0;
    win_release = 1'b0;
    rd_frame    = '0;
    rd_mel      = '0;
    tick();
    tick();
    check("rst_ready", 32'(cnn_ready), 32'd1);
    check("rst_win_valid", 32'(win_valid), 32'd0);
    check("rst_frames_held", 32'(frames_held), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(FILL));
    reset = 1'b1;
    tick();

    // First window: 32 frames, value = frame*40 + mel
    send_frames(0, 1);
    check("held_after_f0", 32'(frames_held), 32'd1);
    send_frames(1, 30);
    for (int m = 0; m < 39; m++) send(16'(31 * 40 + m));
    check("no_win_before_last", 32'(win_valid), 32'd0);
    check("held_before_last", 32'(frames_held), 32'd31);
    send(16'd1279);
    check("win_valid_after_last", 32'(win_valid), 32'd1);
    check("ready_low_in_window", 32'(cnn_ready), 32'd0);
    check("state_window", 32'(dbg_state), 32'(WINDOW));
    check("held_full", 32'(frames_held), 32'd32);
    rd_check("rd_5_7", 5, 7, 207);
    rd_check("rd_31_39", 31, 39, 1279);

    // Valid held high in WINDOW: nothing may be written
    cnn_data  = 16'hBEEF;
    cnn_valid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    cnn_valid = 1'b0;
    check("hold_ready_low", 32'(cnn_ready), 32'd0);
    check("hold_held", 32'(frames_held), 32'd32);
    check("hold_win_valid", 32'(win_valid), 32'd1);
    rd_check("hold_no_overwrite", 0, 0, 0);

    // Release: drop 16 oldest frames
    release_pulse();
    check("rel_held", 32'(frames_held), 32'd16);
    check("rel_ready", 32'(cnn_ready), 32'd1);
    check("rel_win_valid", 32'(win_valid), 32'd0);
    rd_check("rel_rd_0_0", 0, 0, 640);
    rd_check("rel_rd_15_39", 15, 39, 1279);

    // Release while filling is illegal and ignored
    release_pulse();
    check("bad_rel_err", 32'(err), 32'(exp_err));
    check("bad_rel_held", 32'(frames_held), 32'd16);
    check("bad_rel_ready", 32'(cnn_ready), 32'd1);

    // Second window wraps the write pointer back to physical frame 0
    send_frames(32, 16);
    check("win2_valid", 32'(win_valid), 32'd1);
    check("win2_held", 32'(frames_held), 32'd32);
    check("win2_err_sticky", 32'(err), 32'(exp_err));
    rd_check("win2_rd_16_0", 16, 0, 1280);
    rd_check("win2_rd_0_0", 0, 0, 640);
    rd_check("win2_rd_31_39", 31, 39, 1919);

    // Second release wraps the read base to 0
    release_pulse();
    check("rel2_held", 32'(frames_held), 32'd16);
    rd_check("rel2_rd_0_0", 0, 0, 1280);

    // Partial frame then reset mid-stream
    for (int i = 0; i < 20; i++) send(16'(5000 + i));
    check("partial_held", 32'(frames_held), 32'd16);
    reset = 1'b0;
    tick();
    check("mid_rst_held", 32'(frames_held), 32'd0);
    check("mid_rst_ready", 32'(cnn_ready), 32'd1);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_rd_data", 32'(rd_data), 32'd0);
    reset = 1'b1;
    tick();
    rd_check("storage_kept", 1, 0, 1320);
    for (int m = 0; m < 40; m++) send(16'(7000 + m));
    check("restart_held", 32'(frames_held), 32'd1);
    rd_check("restart_rd_0_0", 0, 0, 7000);
    rd_check("restart_rd_0_39", 0, 39, 7039);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_feature_rx.md
CNN_FEATURE_RX -- requirements
Module: cnn_feature_rx

Interface
REQ-001 SHALL have parameter OUT_W, default 16, meaning log-mel sample width.
REQ-002 SHALL have parameter N_MELS, default 40, meaning mel values per frame.
REQ-003 SHALL have parameter N_FRAMES, default 32, meaning frames per CNN window.
REQ-004 SHALL have parameter HOP_FRAMES, default 16, meaning frames retired per window release, legal range 1..N_FRAMES.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port cnn_data_il, input, OUT_W, log-mel sample from the feature stream.
REQ-008 SHALL have port cnn_valid_il, input, 1, sample valid.
REQ-009 SHALL have port cnn_ready_ol, output, 1, receiver can accept a sample.
REQ-010 SHALL have port win_valid_ol, output, 1, a full N_FRAMES window is held and readable.
REQ-011 SHALL have port win_release_il, input, 1, single-cycle pulse; CNN is done with the current window.
REQ-012 SHALL have port rd_frame_il, input, $clog2(N_FRAMES), logical frame index, where 0 is the oldest frame.
REQ-013 SHALL have port rd_mel_il, input, $clog2(N_MELS), mel index for reads.
REQ-014 SHALL have port rd_data_ol, output, OUT_W, read data.
REQ-015 SHALL have port frames_held_ol, output, $clog2(N_FRAMES+1), count of complete frames stored.
REQ-016 SHALL have port err_ol, output, 1, sticky protocol error.

Function
REQ-017 SHALL accept a sample only on a cycle where cnn_valid_il and cnn_ready_ol are both high.
REQ-018 SHALL write each accepted sample to storage at the position (wr_frame, mel_idx).
REQ-019 SHALL increment mel_idx on each accepted sample, wrapping N_MELS-1 to 0.
REQ-020 SHALL, on that wrap, advance wr_frame modulo N_FRAMES and increment frames_held.
REQ-021 SHALL use a two-state FSM: FILL and WINDOW.
REQ-022 SHALL drive cnn_ready_ol = (state==FILL) and win_valid_ol = (state==WINDOW), both decoded from registered state.
REQ-023 SHALL transition FILL to WINDOW in the cycle after acceptance of the last sample of the frame that makes frames_held equal N_FRAMES.
REQ-024 SHALL, on win_release_il in WINDOW: reduce frames_held by HOP_FRAMES, advance rd_base by HOP_FRAMES modulo N_FRAMES, and return to FILL the next cycle.
REQ-025 SHALL, when HOP_FRAMES==N_FRAMES, leave frames_held at 0 after release.
REQ-026 SHALL read physical frame (rd_base + rd_frame_il) mod N_FRAMES, at mel index rd_mel_il.
REQ-027 SHALL register rd_data_ol with exactly 1 cycle read latency; reads are legal in any state.
REQ-028 SHALL hold valid data on rd_data_ol only for complete frames with logical index < frames_held; other addresses return don't-care.
REQ-029 SHALL ignore win_release_il in FILL and set err_ol.
REQ-030 SHALL leave state unchanged when cnn_valid_il is high while cnn_ready_ol is low (no sample accepted).
REQ-031 SHALL preserve data of partially written frames across a WINDOW period; the stream resumes at the saved mel_idx.
REQ-032 SHALL, on a release whose N_FRAMES is not a power of two, apply all modulo arithmetic explicitly with no bit-truncation wrap.

Reset
REQ-033 SHALL, while reset is low: state=FILL, mel_idx=0, wr_frame=0, rd_base=0, frames_held=0, err_ol=0, rd_data_ol=0, cnn_ready_ol=1, win_valid_ol=0.
REQ-034 SHALL abandon any partial frame on reset mid-stream; storage contents are not cleared.

Configuration
REQ-035 SHALL, with CNN_FEATURE_RX_ERR_EN defined, implement err_ol as described, cleared only by reset.
REQ-036 SHALL, without CNN_FEATURE_RX_ERR_EN, tie err_ol to 0 and still ignore an illegal release.

Structure
REQ-037 SHALL place the state enum (FILL, WINDOW) and default N_MELS/N_FRAMES/OUT_W constants in package cnn_rx_pkg.
REQ-038 SHALL place storage in one sub-module cnn_rx_ram: simple dual-port, N_FRAMES*N_MELS x OUT_W, synchronous read, address = frame*N_MELS+mel.

Verification
REQ-039 SHALL verify: after reset, stream 32x40 samples with value = frame*40+mel -> win_valid_ol=1 one cycle after sample 1279, cnn_ready_ol=0, rd(5,7) returns 207 one cycle later.
REQ-040 SHALL verify: in WINDOW, release pulse -> frames_held=16, FILL next cycle; rd(0,0) returns 640.
REQ-041 SHALL verify: with cnn_valid_il held high in WINDOW for 10 cycles -> no accepts, mel_idx unchanged.
REQ-042 SHALL verify: release pulse during FILL -> err_ol=1 with macro defined (0 without), frames_held unchanged.
REQ-043 SHALL verify: stream 20 samples, assert reset low for 1 cycle, restart stream -> first sample lands at frame 0 mel 0, frames_held=0.
REQ-044 SHALL verify: wrap across a second window (16 more frames after release) -> rd(16,0) returns first sample of frame 32 stream, physical frame 0.
